// File: rtl/acs_node.sv
// Add-compare-select node for one trellis state of the hard-decision Viterbi decoder.
// Registers the surviving path metric, the decision bit, a sticky saturation flag and a step counter.
module acs_node #(
    parameter int unsigned     PM_W      = 8,
    parameter int unsigned     STATE_IDX = 0,
    parameter logic [PM_W-1:0] INIT_MAX  = PM_W'(64),
    parameter int unsigned     CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             in_valid,
    input  logic [PM_W-1:0]  pm_a_in,
    input  logic [PM_W-1:0]  pm_b_in,
    input  logic [1:0]       bm_a_in,
    input  logic [1:0]       bm_b_in,
    input  logic             norm_en,
    input  logic [PM_W-1:0]  norm_val,
    output logic [PM_W-1:0]  pm_out,
    output logic             dec_out,
    output logic             out_valid,
    output logic             sat_flag,
    output logic [CNT_W-1:0] step_cnt
);

    localparam int unsigned     SUM_W   = PM_W + 1;
    localparam logic [PM_W-1:0] INIT_PM = (STATE_IDX == 0) ? PM_W'(0) : INIT_MAX;

    logic [SUM_W-1:0] sum_a_w;
    logic [SUM_W-1:0] sum_b_w;
    logic [PM_W-1:0]  sum_a;
    logic [PM_W-1:0]  sum_b;
    logic [PM_W-1:0]  sel;
    logic [PM_W-1:0]  pm_next;
    logic             sat_a;
    logic             sat_b;
    logic             dec_next;

    // Widest sum is (2^PM_W - 1) + 3, so the carry bit alone marks an overflow.
    always_comb begin
        sum_a_w  = {1'b0, pm_a_in} + SUM_W'(bm_a_in);
        sum_b_w  = {1'b0, pm_b_in} + SUM_W'(bm_b_in);
        sat_a    = sum_a_w[PM_W];
        sat_b    = sum_b_w[PM_W];
        sum_a    = sat_a ? '1 : sum_a_w[PM_W-1:0];
        sum_b    = sat_b ? '1 : sum_b_w[PM_W-1:0];
        dec_next = (sum_b < sum_a);
        sel      = dec_next ? sum_b : sum_a;
        pm_next  = sel;
        if (norm_en) begin
            pm_next = (sel >= norm_val) ? (sel - norm_val) : '0;
        end
    end

    // Priority: reset, then frame initialisation, then an accepted step, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pm_out    <= INIT_PM;
            dec_out   <= 1'b0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            step_cnt  <= '0;
        end else if (frame_start) begin
            pm_out    <= INIT_PM;
            dec_out   <= 1'b0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            step_cnt  <= '0;
        end else if (in_valid) begin
            pm_out    <= pm_next;
            dec_out   <= dec_next;
            out_valid <= 1'b1;
            sat_flag  <= sat_flag | sat_a | sat_b;
            if (step_cnt != '1) begin
                step_cnt <= step_cnt + CNT_W'(1);
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acs_node.sv
// Bench for acs_node: directed vector table, multi-cycle corner sequences and random steps
// checked against an integer-arithmetic model of the add-compare-select rules.
module tb_acs_node;

    localparam int unsigned PM_W    = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int          PM_MAX  = (1 << PM_W) - 1;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
    localparam int          INIT1   = 64;

    logic             clk;
    logic             rst_n;
    logic             frame_start;
    logic             in_valid;
    logic [PM_W-1:0]  pm_a_in;
    logic [PM_W-1:0]  pm_b_in;
    logic [1:0]       bm_a_in;
    logic [1:0]       bm_b_in;
    logic             norm_en;
    logic [PM_W-1:0]  norm_val;

    logic [PM_W-1:0]  pm_out1;
    logic             dec_out1;
    logic             out_valid1;
    logic             sat_flag1;
    logic [CNT_W-1:0] step_cnt1;
    logic [PM_W-1:0]  pm_out0;
    logic             dec_out0;
    logic             out_valid0;
    logic             sat_flag0;
    logic [CNT_W-1:0] step_cnt0;

    acs_node #(.PM_W(PM_W), .STATE_IDX(1), .INIT_MAX(8'd64), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
        .pm_a_in(pm_a_in), .pm_b_in(pm_b_in), .bm_a_in(bm_a_in), .bm_b_in(bm_b_in),
        .norm_en(norm_en), .norm_val(norm_val),
        .pm_out(pm_out1), .dec_out(dec_out1), .out_valid(out_valid1),
        .sat_flag(sat_flag1), .step_cnt(step_cnt1)
    );

    acs_node #(.PM_W(PM_W), .STATE_IDX(0), .INIT_MAX(8'd64), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
        .pm_a_in(pm_a_in), .pm_b_in(pm_b_in), .bm_a_in(bm_a_in), .bm_b_in(bm_b_in),
        .norm_en(norm_en), .norm_val(norm_val),
        .pm_out(pm_out0), .dec_out(dec_out0), .out_valid(out_valid0),
        .sat_flag(sat_flag0), .step_cnt(step_cnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Reference state: node 1 (init 64) and node 0 (init 0) differ only in their init metric.
    int m_pm1, m_pm0, m_dec, m_val, m_sat, m_cnt;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_update();
        int sa, sb, sel, d;
        if (!rst_n || frame_start) begin
            m_pm1 = INIT1; m_pm0 = 0; m_dec = 0; m_val = 0; m_sat = 0; m_cnt = 0;
        end else if (in_valid) begin
            sa = int'(pm_a_in) + int'(bm_a_in);
            sb = int'(pm_b_in) + int'(bm_b_in);
            if (sa > PM_MAX) begin sa = PM_MAX; m_sat = 1; end
            if (sb > PM_MAX) begin sb = PM_MAX; m_sat = 1; end
            d   = (sb < sa) ? 1 : 0;
            sel = (d == 1) ? sb : sa;
            if (norm_en) sel = (sel >= int'(norm_val)) ? sel - int'(norm_val) : 0;
            m_pm1 = sel; m_pm0 = sel; m_dec = d; m_val = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_val = 0;
        end
    endtask

    task automatic check_all();
        chk("pm_out",     int'(pm_out1),    m_pm1);
        chk("pm_out_s0",  int'(pm_out0),    m_pm0);
        chk("dec_out",    int'(dec_out1),   m_dec);
        chk("out_valid",  int'(out_valid1), m_val);
        chk("sat_flag",   int'(sat_flag1),  m_sat);
        chk("step_cnt",   int'(step_cnt1),  m_cnt);
    endtask

    // One clock: update the model from the driven inputs, clock the DUT, compare just after the edge.
    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic fs, input logic iv, input int pa, input int ba,
                         input int pb, input int bb, input logic ne, input int nv);
        frame_start = fs; in_valid = iv;
        pm_a_in = PM_W'(pa); bm_a_in = 2'(ba);
        pm_b_in = PM_W'(pb); bm_b_in = 2'(bb);
        norm_en = ne; norm_val = PM_W'(nv);
    endtask

    typedef struct {
        logic fs; logic iv;
        int pa; int ba; int pb; int bb;
        logic ne; int nv;
        int exp_pm; int exp_dec;
    } vec_t;

    vec_t tbl[9];

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0);

        tbl[0] = '{1'b1, 1'b0,   0, 0,   0, 0, 1'b0,  0, 64, 0};
        tbl[1] = '{1'b0, 1'b1,  10, 2,  11, 0, 1'b0,  0, 11, 1};
        tbl[2] = '{1'b0, 1'b0,   0, 0,   0, 0, 1'b0,  0, 11, 1};
        tbl[3] = '{1'b0, 1'b1,   5, 1,   4, 2, 1'b0,  0,  6, 0};
        tbl[4] = '{1'b0, 1'b1,  18, 2,  25, 0, 1'b1,  8, 12, 0};
        tbl[5] = '{1'b0, 1'b1,  18, 2,  25, 0, 1'b1, 30,  0, 0};
        tbl[6] = '{1'b0, 1'b0, 200, 0, 100, 0, 1'b1,  1,  0, 0};
        tbl[7] = '{1'b0, 1'b1, 100, 0,  50, 1, 1'b1, 51,  0, 1};
        tbl[8] = '{1'b0, 1'b1,  10, 3,  20, 3, 1'b0,  0, 13, 0};

        // Reset held for two clocks.
        tick();
        tick();
        chk("rst_pm1",   int'(pm_out1),    64);
        chk("rst_pm0",   int'(pm_out0),    0);
        chk("rst_valid", int'(out_valid1), 0);
        chk("rst_cnt",   int'(step_cnt1),  0);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].fs, tbl[i].iv, tbl[i].pa, tbl[i].ba, tbl[i].pb, tbl[i].bb,
                  tbl[i].ne, tbl[i].nv);
            tick();
            chk($sformatf("vec%0d_pm", i),  int'(pm_out1),  tbl[i].exp_pm);
            chk($sformatf("vec%0d_dec", i), int'(dec_out1), tbl[i].exp_dec);
        end

        // Saturation is sticky across non-saturating steps until frame_start.
        drive(1'b0, 1'b1, 254, 2, 255, 1, 1'b0, 0);
        tick();
        chk("sat_pm",  int'(pm_out1),   255);
        chk("sat_dec", int'(dec_out1),  0);
        chk("sat_set", int'(sat_flag1), 1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, int'($urandom_range(0, 200)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 200)), int'($urandom_range(0, 2)), 1'b0, 0);
            tick();
        end
        chk("sat_sticky", int'(sat_flag1), 1);
        drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0);
        tick();
        chk("sat_clear", int'(sat_flag1), 0);

        // frame_start wins over a coincident in_valid mid-stream.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 30 + i, 1, 40, 2, 1'b0, 0);
            tick();
        end
        chk("prio_cnt5", int'(step_cnt1), 5);
        drive(1'b1, 1'b1, 1, 0, 2, 0, 1'b0, 0);
        tick();
        chk("prio_pm",    int'(pm_out1),    64);
        chk("prio_cnt",   int'(step_cnt1),  0);
        chk("prio_valid", int'(out_valid1), 0);

        // Reset in the middle of a continuous in_valid burst.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 7, 1, 9, 0, 1'b0, 0);
            tick();
        end
        rst_n = 1'b0;
        tick();
        chk("burst_rst_valid", int'(out_valid1), 0);
        chk("burst_rst_pm",    int'(pm_out1),    64);
        rst_n = 1'b1;

        // Long back-to-back run drives step_cnt into its saturation point.
        for (int i = 0; i < 270; i++) begin
            drive(1'b0, 1'b1, int'($urandom_range(0, PM_MAX)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, PM_MAX)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, PM_MAX)));
            tick();
        end
        chk("cnt_hold", int'(step_cnt1), CNT_MAX);

        // Random mix of idle, steps, normalisation and occasional frame restarts.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, PM_MAX)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, PM_MAX)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 64)));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acs_node.md
Name: acs_node

Overview:
Add-compare-select stage directly downstream of the branch-metric cells in the hard-decision Viterbi decoder. One instance per trellis state. Each instance takes the two 2-bit Hamming branch metrics feeding its state and the path metrics of the two predecessor states. It registers the surviving path metric and a one-bit decision for the traceback memory. It also provides frame initialisation, saturation, external normalisation and a step counter.

Parameters:
PM_W, 8, path-metric width in bits (unsigned)
STATE_IDX, 0, trellis state index of this node; selects the init value
INIT_MAX, 8'd64, init metric for every state other than 0 (must be < 2^PM_W)
CNT_W, 8, step-counter width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
frame_start  input  1  load init metric, clear counter and sat_flag
in_valid  input  1  one trellis step available this cycle
pm_a_in  input  PM_W  path metric of predecessor A (decision 0)
pm_b_in  input  PM_W  path metric of predecessor B (decision 1)
bm_a_in  input  2  branch metric on A->this transition (0..2)
bm_b_in  input  2  branch metric on B->this transition (0..2)
norm_en  input  1  subtract norm_val from the selected metric this step
norm_val  input  PM_W  normalisation amount (global minimum from the decoder)
pm_out  output  PM_W  registered surviving path metric
dec_out  output  1  registered decision bit (1 = B survived)
out_valid  output  1  pm_out/dec_out updated by the previous cycle's step
sat_flag  output  1  sticky: a sum saturated since the last frame_start/reset
step_cnt  output  CNT_W  steps processed since frame_start; saturates at all-ones

Behaviour:
- Reset (rst_n=0 at a clk edge): pm_out=init (0 if STATE_IDX==0, else INIT_MAX). dec_out=0, out_valid=0, sat_flag=0, step_cnt=0. Reset overrides all other inputs.
- Priority per edge: reset > frame_start > in_valid > hold.
- frame_start=1: pm_out=init, dec_out=0, out_valid=0, sat_flag=0, step_cnt=0. A coincident in_valid is dropped.
- in_valid=1 (no frame_start), all results registered with 1-cycle latency:
  - sum_a=pm_a_in+bm_a_in, sum_b=pm_b_in+bm_b_in, computed at PM_W+1 bits.
  - Any sum > 2^PM_W-1 is clamped to 2^PM_W-1 and sets sat_flag (sticky).
  - dec = (sum_b < sum_a). Ties select A, so dec=0.
  - sel = dec ? sum_b : sum_a (post-clamp).
  - If norm_en: pm_out = (sel >= norm_val) ? sel-norm_val : 0. Otherwise pm_out = sel.
  - dec_out=dec, out_valid=1, step_cnt+1, holding at 2^CNT_W-1.
- in_valid=0: pm_out, dec_out, sat_flag and step_cnt hold; out_valid=0 the next cycle.
- out_valid is a single-cycle pulse per accepted step. Back-to-back in_valid gives continuous out_valid.
- bm inputs of 3 are arithmetically legal (treated as value 3); no checking.
- norm_en with in_valid=0 is ignored.

Test Plan:
- Reset: STATE_IDX=1, hold rst_n=0 for 2 clks -> pm_out=64, dec_out=0, out_valid=0, sat_flag=0, step_cnt=0. Repeat with STATE_IDX=0 -> pm_out=0.
- Select B: pm_a=10, bm_a=2, pm_b=11, bm_b=0, in_valid for 1 clk -> next cycle pm_out=11, dec_out=1, out_valid=1, step_cnt=1. Following idle cycle -> out_valid=0, pm_out holds 11.
- Tie: pm_a=5, bm_a=1, pm_b=4, bm_b=2 -> pm_out=6, dec_out=0.
- Saturation: pm_a=254, bm_a=2, pm_b=255, bm_b=1 -> pm_out=255, dec_out=0, sat_flag=1. sat_flag stays 1 over 10 further non-saturating steps. frame_start clears it.
- Normalisation: sums 20/25 with norm_en=1, norm_val=8 -> pm_out=12, dec_out=0. Same sums with norm_val=30 -> pm_out=0.
- Priority: frame_start and in_valid asserted together mid-stream (step_cnt=5) -> pm_out=init, step_cnt=0, out_valid=0. rst_n=0 during a continuous in_valid burst -> reset values the next cycle, no out_valid.
